// File: rtl/lab2_operand_sequencer.sv
// lab2_operand_sequencer: single-key operand entry (A, then B + op) for the 4-bit adder/subtractor.
// Define LAB2_SEQ_DEBOUNCE_EN to include the key debounce filter; undefined, the synchronizer drives the edge detector.
module lab2_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   input  logic [3:0] sw_data,
   input  logic       sw_op,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic       k,
   input  logic [3:0] sum,
   output logic [3:0] result,
   output logic       overflow,
   output logic       result_valid,
   output logic [3:0] state_leds
);
   // state  | meaning
   // WAIT_A | waiting for the press that latches operand A
   // WAIT_B | waiting for the press that latches operand B and the operation
   // CALC   | one cycle: capture adder sum and signed overflow
   // SHOW   | result displayed; next press returns to WAIT_A
   typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SHOW} state_t;

   if (DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic sync1_q, sync1_d, sync2_q, sync2_d;
   logic deb_lvl;
   logic deb_dly_q, deb_dly_d;
   logic press_q, press_d;

`ifdef LAB2_SEQ_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign deb_lvl = deb_q;
`else
   assign deb_lvl = sync2_q;
`endif

   always_comb begin
      sync1_d   = key_n;
      sync2_d   = sync1_q;
      deb_dly_d = deb_lvl;
      press_d   = deb_dly_q & ~deb_lvl;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         deb_dly_q <= 1'b1;
         press_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_dly_q <= deb_dly_d;
         press_q   <= press_d;
      end
   end

   state_t     state_q;
   logic [3:0] a_q, b_q, result_q, leds_q;
   logic       k_q, ovf_q, valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WAIT_A;
         leds_q   <= 4'b0001;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         k_q      <= 1'b0;
         result_q <= 4'd0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            WAIT_A: if (press_q) begin
               a_q     <= sw_data;
               state_q <= WAIT_B;
               leds_q  <= 4'b0010;
            end
            WAIT_B: if (press_q) begin
               b_q     <= sw_data;
               k_q     <= sw_op;
               state_q <= CALC;
               leds_q  <= 4'b0100;
            end
            CALC: begin
               result_q <= sum;
               ovf_q    <= (a_q[3] == (b_q[3] ^ k_q)) && (sum[3] != a_q[3]);
               valid_q  <= 1'b1;
               state_q  <= SHOW;
               leds_q   <= 4'b1000;
            end
            default: if (press_q) begin
               valid_q <= 1'b0;
               state_q <= WAIT_A;
               leds_q  <= 4'b0001;
            end
         endcase
      end
   end

   assign a            = a_q;
   assign b            = b_q;
   assign k            = k_q;
   assign result       = result_q;
   assign overflow     = ovf_q;
   assign result_valid = valid_q;
   assign state_leds   = leds_q;
endmodule

// File: tb/tb_lab2_operand_sequencer.sv
// Self-checking bench for lab2_operand_sequencer with a behavioural 4-bit adder/subtractor on sum.
module tb_lab2_operand_sequencer;
   localparam int DEB = 4;
`ifdef LAB2_SEQ_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst, key_n, sw_op, k, overflow, result_valid;
   logic [3:0] sw_data, a, b, sum, result, state_leds;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_key   = 0;
   logic [4:0] sb_q[$];
   logic       valid_prev = 1'b0;

   lab2_operand_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .sw_data(sw_data), .sw_op(sw_op),
      .a(a), .b(b), .k(k), .sum(sum), .result(result), .overflow(overflow),
      .result_valid(result_valid), .state_leds(state_leds)
   );

   assign sum = k ? (a - b) : (a + b);

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: each rising result_valid pops one expected {result, overflow}.
   always @(negedge clk) begin
      logic [4:0] e;
      if (result_valid && !valid_prev) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 16'd1, 16'd0);
         end else begin
            e = sb_q.pop_front();
            check("result", {12'd0, result}, {12'd0, e[4:1]});
            check("overflow", {15'd0, overflow}, {15'd0, e[0]});
            check("valid_latency", 16'(cyc - t_key), 16'(LAT + 2));
         end
      end
      valid_prev = result_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_key(input logic [3:0] d, input logic op, input string tag);
      logic [3:0] leds0, leds1;
      int hit;
      tick(1);
      sw_data = d;
      sw_op   = op;
      key_n   = 1'b0;
      t_key   = cyc;
      leds0   = state_leds;
      hit     = -1;
      for (int n = 0; n < LAT + 6 && hit < 0; n++) begin
         @(negedge clk);
         if (state_leds !== leds0) hit = cyc - t_key;
      end
      check({tag, "_press_latency"}, 16'(hit), 16'(LAT + 1));
      sw_data = ~d;
      sw_op   = ~op;
      tick(2);
      leds1 = state_leds;
      key_n = 1'b1;
      tick(LAT + 4);
      check({tag, "_release_no_press"}, {12'd0, state_leds}, {12'd0, leds1});
   endtask

   task automatic do_calc(input logic [3:0] va, input logic [3:0] vb, input logic op);
      int sa, sb, full;
      logic [3:0] s;
      logic ov;
      sa   = $signed(va);
      sb   = $signed(vb);
      full = op ? sa - sb : sa + sb;
      s    = 4'(full);
      ov   = (full > 7) || (full < -8);
      sb_q.push_back({s, ov});
      press_key(va, 1'b0, "a");
      check("a_latched", {12'd0, a}, {12'd0, va});
      check("state_wait_b", {12'd0, state_leds}, 16'b0010);
      press_key(vb, op, "b");
      check("a_held", {12'd0, a}, {12'd0, va});
      check("b_latched", {12'd0, b}, {12'd0, vb});
      check("k_latched", {15'd0, k}, {15'd0, op});
      check("state_show", {12'd0, state_leds}, 16'b1000);
      check("valid_in_show", {15'd0, result_valid}, 16'd1);
      press_key(4'hF, 1'b1, "show");
      check("valid_cleared", {15'd0, result_valid}, 16'd0);
      check("state_wait_a", {12'd0, state_leds}, 16'b0001);
      check("result_kept", {12'd0, result}, {12'd0, s});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; key_n = 1'b1; sw_data = 4'd0; sw_op = 1'b0;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("rst_leds", {12'd0, state_leds}, 16'b0001);
      check("rst_outputs", {5'd0, a, b, k, result, overflow}, 16'd0);
      check("rst_valid", {15'd0, result_valid}, 16'd0);
      tick(50);
      check("idle_leds", {12'd0, state_leds}, 16'b0001);

      do_calc(4'd3, 4'd4, 1'b0);
      do_calc(4'b1000, 4'd1, 1'b1);
      do_calc(4'd3, 4'd5, 1'b1);
      do_calc(4'd7, 4'd1, 1'b0);

`ifdef LAB2_SEQ_DEBOUNCE_EN
      key_n = 1'b0; tick(3);
      key_n = 1'b1; tick(2);
      key_n = 1'b0; tick(3);
      key_n = 1'b1; tick(10);
      check("bounce_rejected", {12'd0, state_leds}, 16'b0001);
      check("bounce_a_kept", {12'd0, a}, 16'd7);
`endif

      for (int i = 0; i < 4; i++) begin
         do_calc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      press_key(4'd9, 1'b0, "a9");
      check("a9_latched", {12'd0, a}, 16'd9);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_a", {12'd0, a}, 16'd0);
      check("midrst_leds", {12'd0, state_leds}, 16'b0001);
      check("midrst_valid", {15'd0, result_valid}, 16'd0);

      do_calc(4'd2, 4'd6, 1'b0);
      tick(3);
      check("scoreboard_empty", 16'(sb_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lab2_operand_sequencer.md
# lab2_operand_sequencer

Sequential front-end for the 4-bit adder/subtractor stage. Replaces direct switch-to-operand wiring. The operator enters A, then B and the operation, with one pushbutton; the block latches them, drives the adder, and captures its sum and signed-overflow status in registers for the decimal/hex display stage. It sits between the board switches/KEY inputs and `lab2_adder_subtractor_parametrizable`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000, consecutive stable samples needed to accept a key level change (10 ms at 50 MHz). Must be ≥ 2.
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `key_n`  input  1  raw pushbutton, active-low, asynchronous to `clk`.
- `sw_data`  input  4  operand value from switches.
- `sw_op`  input  1  operation select: 0 = add, 1 = subtract.
- `a`  output  4  latched operand A, to the adder.
- `b`  output  4  latched operand B, to the adder.
- `k`  output  1  latched operation, to the adder `K`.
- `sum`  input  4  adder result, combinational from `a`/`b`/`k`.
- `result`  output  4  registered sum.
- `overflow`  output  1  registered signed (two's-complement) overflow of `result`.
- `result_valid`  output  1  high while `result`/`overflow` hold a completed calculation.
- `state_leds`  output  4  one-hot state: bit0 WAIT_A, bit1 WAIT_B, bit2 CALC, bit3 SHOW.

## Operation
- Input path: 2-flop synchronizer on `key_n` → debounce filter → falling-edge detector. The edge detector produces `press`, a one-cycle internal pulse.
- The debounced level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any sample equal to the current debounced level clears the counter.
- FSM:
  - WAIT_A: on `press`, `a` ← `sw_data` and go to WAIT_B.
  - WAIT_B: on `press`, `b` ← `sw_data`, `k` ← `sw_op`, and go to CALC.
  - CALC: exactly one cycle. `result` ← `sum`; `overflow` ← (`a[3]` == (`b[3]` ^ `k`)) && (`sum[3]` != `a[3]`); `result_valid` ← 1. Go to SHOW.
  - SHOW: on `press`, `result_valid` ← 0 and go to WAIT_A. `a`, `b`, `k`, `result` keep their values until overwritten.
- `press` in CALC is ignored; it is not queued.
- Switch changes outside the capturing `press` cycle have no effect on `a`/`b`/`k`.
- `result` is the raw 4-bit sum. Any carry out of bit 3 is discarded.
- Overflow examples:
  - 7 + 1 → `result` 4'b1000, `overflow` 1.
  - −8 − 1 → `result` 4'b0111, `overflow` 1.
  - 3 − 5 → `result` 4'b1110, `overflow` 0.

## Timing
- Reset values: `a` 0, `b` 0, `k` 0, `result` 0, `overflow` 0, `result_valid` 0, `state_leds` 4'b0001. Synchronizer flops and debounced level reset to 1 (released); debounce counter 0.
- `rst` overrides everything, including mid-debounce and in CALC. The next cycle is WAIT_A with all reset values.
- With `key_n` held low from cycle 0, `press` is high in exactly cycle `DEBOUNCE_CYCLES`+3. The state/operand registers update at the end of that cycle.
- Release (`key_n` low → high) never produces `press`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `press`.
- CALC → SHOW occurs on the cycle after WAIT_B → CALC. `result_valid` rises 2 cycles after the B `press` cycle.
- `a`, `b`, `k` are registered outputs; the adder path (`a`/`b`/`k` → `sum` → `result`) is one cycle.

## Configuration
- `LAB2_SEQ_DEBOUNCE_EN` defined:
  - Debounce filter present, as described above.
- `LAB2_SEQ_DEBOUNCE_EN` undefined:
  - Filter removed; the debounced level equals the synchronizer output.
  - `press` occurs in cycle 3 after `key_n` is first low.
  - `DEBOUNCE_CYCLES` is ignored.
  - Intended for simulation.

## Test plan
- Reset then idle: `rst` high 2 cycles → `state_leds` 4'b0001, all outputs 0, `result_valid` 0; `key_n` high 50 cycles → no state change.
- Add sequence (`DEBOUNCE_CYCLES`=4, macro defined): A=3, press; B=4, `sw_op`=0, press → `a`=3, `b`=4, `k`=0; `result`=7, `overflow`=0, `result_valid`=1 two cycles after B press; `state_leds` 4'b1000.
- Subtract overflow: A=4'b1000, B=1, `sw_op`=1 → `result`=4'b0111, `overflow`=1; then A=3, B=5, `sw_op`=1 → `result`=4'b1110, `overflow`=0.
- Bounce rejection: `key_n` low 3 cycles, high 2, low 3 (`DEBOUNCE_CYCLES`=4) → no `press`, state unchanged. Then hold low 10 cycles → exactly one transition, in cycle 7 of the hold.
- Return from SHOW: press in SHOW → `result_valid` 0 next cycle; `state_leds` 4'b0001; `result` unchanged.
- Reset mid-operation: `rst` asserted in WAIT_B with `a`=9 → next cycle `a`=0, state WAIT_A. Macro undefined: press registers 3 cycles after `key_n` falls.
